// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the boot sequencer / memory arbiter slice.
package riscv_mem_pkg;

  typedef enum logic {
    BOOT,
    RUN
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_D
  } port_tag_t;

  localparam logic [3:0] WORD_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Delay line carrying the owner tag of each granted read until its data returns.
module mem_rd_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  port_tag_t i_tag,
  output port_tag_t o_tag
);

  port_tag_t r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= TAG_NONE;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Holds the core in reset while the loader fills memory, then round-robins
// fetch and data traffic onto one pipelined memory port.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              ld_done,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_reset
);

  arb_state_t r_state, w_state_next;
  logic       r_last_d;
  logic       w_ld_gnt, w_if_gnt, w_d_gnt;
  port_tag_t  w_tag_in, w_tag_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= BOOT;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_d_gnt) begin
        r_last_d <= 1'b1;
      end else if (w_if_gnt) begin
        r_last_d <= 1'b0;
      end
    end
  end

  // Grants are gated by reset_n so every output is quiet while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_ld_gnt     = 1'b0;
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_ld_gnt = reset_n & ld_req;
        if (ld_done) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (if_req && d_req) begin
          w_if_gnt = r_last_d;
          w_d_gnt  = ~r_last_d;
        end else begin
          w_if_gnt = if_req;
          w_d_gnt  = d_req;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_be    = WORD_BE_ALL;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (w_d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : WORD_BE_ALL;
      mem_addr  = d_addr;
      mem_wdata = d_we ? d_wdata : '0;
    end else if (w_if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = WORD_BE_ALL;
      mem_addr = if_addr;
    end
  end

  always_comb begin
    w_tag_in = TAG_NONE;
    if (w_if_gnt) begin
      w_tag_in = TAG_IF;
    end else if (w_d_gnt && !d_we) begin
      w_tag_in = TAG_D;
    end
  end

  mem_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  assign ld_gnt     = w_ld_gnt;
  assign if_gnt     = w_if_gnt;
  assign d_gnt      = w_d_gnt;
  assign if_rvalid  = (w_tag_out == TAG_IF);
  assign d_rvalid   = (w_tag_out == TAG_D);
  assign if_rdata   = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign core_reset = (r_state == BOOT);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Drives one stimulus stream into two arbiters (read latency 1 and 3), each
// with its own memory model, and checks both against hand-computed vectors.
module tb_riscv_mem_arbiter;

  typedef enum logic [2:0] {OP_IDLE, OP_BOTH, OP_IF, OP_DRD, OP_DWR, OP_LATE} op_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_D} who_t;

  typedef struct {
    op_t         op;
    logic [29:0] ia;
    logic [29:0] da;
    who_t        g;
    who_t        rv_a;
    logic [31:0] dat_a;
    who_t        rv_b;
    logic [31:0] dat_b;
  } vec_t;

  typedef struct packed {
    logic        ld_gnt;
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic        d_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
  } obs_t;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] W5   = 32'h1122_3344;
  localparam logic [31:0] W5B  = 32'h1122_CC44;

  logic clk = 1'b0;
  logic reset_n;
  logic ld_req, ld_done, if_req, d_req, d_we;
  logic [29:0] ld_addr, if_addr, d_addr;
  logic [31:0] ld_wdata, d_wdata;
  logic [3:0] d_be;

  logic ld_gnt_a, if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, mem_en_a, mem_we_a, core_reset_a;
  logic ld_gnt_b, if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b, mem_we_b, core_reset_b;
  logic [31:0] if_rdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] if_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [3:0] mem_be_a, mem_be_b;
  logic [29:0] mem_addr_a, mem_addr_b;
  obs_t obs_a, obs_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt_a), .ld_done(ld_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a),
    .if_rdata(if_rdata_a),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_be(mem_be_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .core_reset(core_reset_a)
  );

  riscv_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt_b), .ld_done(ld_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b),
    .if_rdata(if_rdata_b),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .core_reset(core_reset_b)
  );

  assign obs_a = {ld_gnt_a, if_gnt_a, d_gnt_a, if_rvalid_a, d_rvalid_a, if_rdata_a, d_rdata_a,
                  mem_en_a, mem_we_a, mem_be_a, mem_addr_a, mem_wdata_a, core_reset_a};
  assign obs_b = {ld_gnt_b, if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, if_rdata_b, d_rdata_b,
                  mem_en_b, mem_we_b, mem_be_b, mem_addr_b, mem_wdata_b, core_reset_b};

  // Byte-enabled memory models; read data appears 1 and 3 cycles after the access edge.
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] rd_a;
  logic [31:0] rd_b [3];

  always @(posedge clk) begin
    if (mem_en_a && mem_we_a) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_a[i]) mem_a[mem_addr_a[5:0]][8*i +: 8] <= mem_wdata_a[8*i +: 8];
      end
    end
    rd_a <= mem_a[mem_addr_a[5:0]];
  end

  always @(posedge clk) begin
    if (mem_en_b && mem_we_b) begin
      for (int j = 0; j < 4; j++) begin
        if (mem_be_b[j]) mem_b[mem_addr_b[5:0]][8*j +: 8] <= mem_wdata_b[8*j +: 8];
      end
    end
    rd_b[0] <= mem_b[mem_addr_b[5:0]];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end

  assign mem_rdata_a = rd_a;
  assign mem_rdata_b = rd_b[2];

  task automatic chk1(input string n, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", n, act, exp);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_t op, input logic [29:0] ia, input logic [29:0] da,
                              input who_t g, input who_t ra, input logic [31:0] xa,
                              input who_t rb, input logic [31:0] xb);
    vec_t v;
    v.op = op; v.ia = ia; v.da = da; v.g = g;
    v.rv_a = ra; v.dat_a = xa; v.rv_b = rb; v.dat_b = xb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ld_req = 1'b0; ld_done = 1'b0; ld_addr = '0; ld_wdata = '0;
    if_req = 1'b0; if_addr = v.ia;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = v.da; d_wdata = '0;
    case (v.op)
      OP_BOTH: begin if_req = 1'b1; d_req = 1'b1; end
      OP_IF:   if_req = 1'b1;
      OP_DRD:  d_req = 1'b1;
      OP_DWR:  begin d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_wdata = 32'hAABB_CCDD; end
      OP_LATE: begin ld_req = 1'b1; ld_done = 1'b1; ld_wdata = 32'hFFFF_FFFF; end
      default: ;
    endcase
  endtask

  task automatic chk_run(input string t, input obs_t o, input vec_t v, input who_t rv,
                         input logic [31:0] dat);
    logic [29:0] ea;
    logic        ewr;
    ea  = (v.g == G_IF) ? v.ia : (v.g == G_D) ? v.da : 30'd0;
    ewr = (v.g == G_D) && (v.op == OP_DWR);
    chk1({t, " ld_gnt"}, o.ld_gnt, 1'b0);
    chk1({t, " if_gnt"}, o.if_gnt, v.g == G_IF);
    chk1({t, " d_gnt"}, o.d_gnt, v.g == G_D);
    chk1({t, " mem_en"}, o.mem_en, v.g != G_NONE);
    chk1({t, " mem_we"}, o.mem_we, ewr);
    chk32({t, " mem_addr"}, 32'(o.mem_addr), 32'(ea));
    if (ewr || v.g == G_NONE) begin
      chk32({t, " mem_be"}, 32'(o.mem_be), ewr ? 32'h2 : 32'h0);
      chk32({t, " mem_wdata"}, o.mem_wdata, ewr ? 32'hAABB_CCDD : 32'h0);
    end
    chk1({t, " core_reset"}, o.core_reset, 1'b0);
    chk1({t, " if_rvalid"}, o.if_rvalid, rv == G_IF);
    chk1({t, " d_rvalid"}, o.d_rvalid, rv == G_D);
    if (rv == G_IF) chk32({t, " if_rdata"}, o.if_rdata, dat);
    if (rv == G_D) chk32({t, " d_rdata"}, o.d_rdata, dat);
  endtask

  task automatic chk_quiet(input string t, input obs_t o);
    chk1({t, " core_reset"}, o.core_reset, 1'b1);
    chk1({t, " ld_gnt"}, o.ld_gnt, 1'b0);
    chk1({t, " if_gnt"}, o.if_gnt, 1'b0);
    chk1({t, " d_gnt"}, o.d_gnt, 1'b0);
    chk1({t, " mem_en"}, o.mem_en, 1'b0);
    chk1({t, " if_rvalid"}, o.if_rvalid, 1'b0);
    chk1({t, " d_rvalid"}, o.d_rvalid, 1'b0);
  endtask

  vec_t        vt [23];
  logic [29:0] boot_addr [6];
  logic [31:0] boot_data [6];

  initial begin
    vt[0]  = mk(OP_BOTH, 0, 8, G_D,    G_NONE, 0,    G_NONE, 0);
    vt[1]  = mk(OP_BOTH, 0, 8, G_IF,   G_D,    BEEF, G_NONE, 0);
    vt[2]  = mk(OP_BOTH, 0, 8, G_D,    G_IF,   NOP,  G_NONE, 0);
    vt[3]  = mk(OP_BOTH, 0, 8, G_IF,   G_D,    BEEF, G_D,    BEEF);
    vt[4]  = mk(OP_IF,   0, 0, G_IF,   G_IF,   NOP,  G_IF,   NOP);
    vt[5]  = mk(OP_IF,   1, 0, G_IF,   G_IF,   NOP,  G_D,    BEEF);
    vt[6]  = mk(OP_IF,   2, 0, G_IF,   G_IF,   NOP,  G_IF,   NOP);
    vt[7]  = mk(OP_IF,   3, 0, G_IF,   G_IF,   NOP,  G_IF,   NOP);
    vt[8]  = mk(OP_DWR,  0, 5, G_D,    G_IF,   NOP,  G_IF,   NOP);
    vt[9]  = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_IF,   NOP);
    vt[10] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_IF,   NOP);
    vt[11] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_NONE, 0);
    vt[12] = mk(OP_DRD,  0, 5, G_D,    G_NONE, 0,    G_NONE, 0);
    vt[13] = mk(OP_IDLE, 0, 0, G_NONE, G_D,    W5B,  G_NONE, 0);
    vt[14] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_NONE, 0);
    vt[15] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_D,    W5B);
    vt[16] = mk(OP_LATE, 0, 0, G_NONE, G_NONE, 0,    G_NONE, 0);
    vt[17] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_NONE, 0);
    vt[18] = mk(OP_BOTH, 1, 8, G_IF,   G_NONE, 0,    G_NONE, 0);
    vt[19] = mk(OP_BOTH, 1, 8, G_D,    G_IF,   NOP,  G_NONE, 0);
    vt[20] = mk(OP_IDLE, 0, 0, G_NONE, G_D,    BEEF, G_NONE, 0);
    vt[21] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_IF,   NOP);
    vt[22] = mk(OP_IDLE, 0, 0, G_NONE, G_NONE, 0,    G_D,    BEEF);
    boot_addr[0] = 0; boot_addr[1] = 1; boot_addr[2] = 2;
    boot_addr[3] = 3; boot_addr[4] = 5; boot_addr[5] = 8;
    boot_data[0] = NOP; boot_data[1] = NOP; boot_data[2] = NOP;
    boot_data[3] = NOP; boot_data[4] = W5; boot_data[5] = BEEF;

    // Reset with every requester active: nothing may be granted.
    reset_n = 1'b0;
    drive(mk(OP_BOTH, 0, 8, G_NONE, G_NONE, 0, G_NONE, 0));
    ld_req = 1'b1;
    #3;
    chk_quiet("rst a", obs_a);
    chk_quiet("rst b", obs_b);
    chk1("rst mem_we", mem_we_a, 1'b0);
    chk32("rst mem_addr", 32'(mem_addr_a), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Boot fill while fetch and data requests are already held high.
    for (int i = 0; i < 6; i++) begin
      ld_req = 1'b1; ld_addr = boot_addr[i]; ld_wdata = boot_data[i]; ld_done = (i == 5);
      @(negedge clk);
      chk1($sformatf("boot%0d ld_gnt a", i), ld_gnt_a, 1'b1);
      chk1($sformatf("boot%0d ld_gnt b", i), ld_gnt_b, 1'b1);
      chk1($sformatf("boot%0d mem_we", i), mem_we_a, 1'b1);
      chk32($sformatf("boot%0d mem_be", i), 32'(mem_be_a), 32'hF);
      chk32($sformatf("boot%0d mem_addr", i), 32'(mem_addr_a), 32'(boot_addr[i]));
      chk32($sformatf("boot%0d mem_wdata", i), mem_wdata_a, boot_data[i]);
      chk1($sformatf("boot%0d if_gnt", i), if_gnt_a | if_gnt_b, 1'b0);
      chk1($sformatf("boot%0d d_gnt", i), d_gnt_a | d_gnt_b, 1'b0);
      chk1($sformatf("boot%0d core_reset", i), core_reset_a & core_reset_b, 1'b1);
      @(posedge clk); #1;
    end

    // Run-phase vector table, first vector is the cycle after the ld_done edge.
    for (int k = 0; k < 23; k++) begin
      drive(vt[k]);
      @(negedge clk);
      chk_run($sformatf("v%0d a", k), obs_a, vt[k], vt[k].rv_a, vt[k].dat_a);
      chk_run($sformatf("v%0d b", k), obs_b, vt[k], vt[k].rv_b, vt[k].dat_b);
      @(posedge clk); #1;
    end

    // Two reads in flight, then an asynchronous reset pulse.
    drive(mk(OP_IF, 0, 0, G_IF, G_NONE, 0, G_NONE, 0));
    @(negedge clk);
    chk1("inflight0 if_gnt", if_gnt_a & if_gnt_b, 1'b1);
    @(posedge clk); #1;
    drive(mk(OP_DRD, 0, 8, G_D, G_NONE, 0, G_NONE, 0));
    @(negedge clk);
    chk1("inflight1 d_gnt", d_gnt_a & d_gnt_b, 1'b1);
    @(posedge clk); #1;
    drive(mk(OP_BOTH, 0, 8, G_NONE, G_NONE, 0, G_NONE, 0));
    #1 reset_n = 1'b0;
    #1;
    chk_quiet("midrst a", obs_a);
    chk_quiet("midrst b", obs_b);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_quiet($sformatf("postrst%0d a", c), obs_a);
      chk_quiet($sformatf("postrst%0d b", c), obs_b);
      @(posedge clk); #1;
    end
    ld_req = 1'b1; ld_addr = 30'd9; ld_wdata = 32'h1234_5678;
    @(negedge clk);
    chk1("reboot ld_gnt a", ld_gnt_a, 1'b1);
    chk1("reboot ld_gnt b", ld_gnt_b, 1'b1);
    chk1("reboot if_gnt", if_gnt_a | if_gnt_b, 1'b0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
